// File: rtl/lcg_check_pkg.sv
// rtl/lcg_check_pkg.sv - shared constants, state encoding and step functions for the LCG stream checker
package lcg_check_pkg;

    localparam logic [31:0] LCG_MUL   = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC   = 32'h3039;
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One LCG step; the result wraps modulo 2^32 by construction.
    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * LCG_MUL + LCG_INC;
    endfunction

    // Shift the signature left one place, folding the polynomial back in on carry-out.
    function automatic logic [31:0] misr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/lcg_stream_checker_if.sv
// rtl/lcg_stream_checker_if.sv - beat stream handshake between a source and the checker
interface lcg_stream_checker_if #(
    parameter int DATA_W = 257
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/lcg_step.sv
// rtl/lcg_step.sv - 32-bit LCG state register with seed load and advance enable
module lcg_step
    import lcg_check_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] seed,
    output logic [31:0] cur,
    output logic [31:0] nxt
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    assign cur = state_q;
    assign nxt = lcg_next(state_q);

    // Load has priority so a new run always starts from the requested seed.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (adv) begin
            state_d = nxt;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 32'h0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/lcg_stream_checker.sv
// rtl/lcg_stream_checker.sv - regenerates LCG beats and checks a received stream; LCG_CHECK_MISR_EN adds a MISR signature
module lcg_stream_checker
    import lcg_check_pkg::*;
#(
    parameter int DATA_W = 257,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed,
    input  logic [CNT_W-1:0]     num_beats,
    lcg_stream_checker_if.slave  s_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_err_beat,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic [31:0]          sig
);

    localparam int NW    = (DATA_W + 31) / 32;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    // All but the last word are held here; the last word is the LCG state itself once FILL ends.
    localparam int LO_W  = (NW > 1) ? (NW - 1) * 32 : 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [LO_W-1:0]     exp_lo_q, exp_lo_d;
    logic [CNT_W-1:0]    num_beats_q, num_beats_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    first_q, first_d;

    logic                rng_load;
    logic                rng_adv;
    logic [31:0]         rng_cur;
    logic [31:0]         rng_nxt;
    logic [DATA_W-1:0]   exp_beat;
    logic                mismatch;
    logic                accept;
    logic                start_ok;
    logic                last_beat;

    lcg_step u_lcg_step (
        .clk  (clk),
        .rst  (rst),
        .load (rng_load),
        .adv  (rng_adv),
        .seed (seed),
        .cur  (rng_cur),
        .nxt  (rng_nxt)
    );

    generate
        if (NW > 1) begin : g_multi_word
            assign exp_beat = DATA_W'({rng_cur, exp_lo_q});
        end else begin : g_single_word
            assign exp_beat = DATA_W'(rng_cur);
        end
    endgenerate

    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign accept    = (state_q == READY) && s_in.in_valid;
    assign mismatch  = (s_in.in_data != exp_beat);
    assign last_beat = (CNT_W'(beat_cnt_q + CNT_W'(1)) == num_beats_q);

    assign s_in.in_ready  = (state_q == READY);
    assign busy           = (state_q == FILL) || (state_q == READY);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_beat = first_q;
    assign beat_cnt       = beat_cnt_q;

    // Run sequencing: fill the expected beat one word per cycle, then compare one received beat.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        exp_lo_d    = exp_lo_q;
        num_beats_d = num_beats_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        first_d     = first_q;
        rng_load    = 1'b0;
        rng_adv     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rng_load    = 1'b1;
                    word_idx_d  = '0;
                    beat_cnt_d  = '0;
                    err_d       = '0;
                    first_d     = '0;
                    num_beats_d = num_beats;
                    state_d     = (num_beats == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                rng_adv = 1'b1;
                if (word_idx_q != LAST_IDX) begin
                    // Shift each new word in from the top so word 0 ends at the bottom.
                    exp_lo_d   = LO_W'({rng_nxt, exp_lo_q} >> 32);
                    word_idx_d = word_idx_q + IDX_W'(1);
                end else begin
                    word_idx_d = '0;
                    state_d    = READY;
                end
            end
            READY: begin
                if (s_in.in_valid) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (err_q == '0) begin
                            first_d = beat_cnt_q;
                        end
                    end
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        word_idx_d = '0;
                        state_d    = FILL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_idx_q  <= '0;
            exp_lo_q    <= '0;
            num_beats_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            exp_lo_q    <= exp_lo_d;
            num_beats_q <= num_beats_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

`ifdef LCG_CHECK_MISR_EN
    logic [31:0] sig_q, sig_d;

    // XOR of all 32-bit chunks of a beat, top chunk zero-padded.
    function automatic logic [31:0] fold32(input logic [DATA_W-1:0] d);
        logic [NW*32-1:0] padded;
        logic [31:0]      acc;
        padded             = '0;
        padded[DATA_W-1:0] = d;
        acc                = 32'h0;
        for (int i = 0; i < NW; i++) begin
            acc = acc ^ padded[i*32 +: 32];
        end
        return acc;
    endfunction

    // Signature compaction over every accepted beat, restarted with each run.
    always_comb begin
        sig_d = sig_q;
        if (start_ok) begin
            sig_d = 32'h0;
        end else if (accept) begin
            sig_d = misr_step(sig_q) ^ fold32(s_in.in_data);
        end
    end

    // Signature register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 32'h0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    logic unused_misr;
    assign unused_misr = start_ok ^ accept;
    assign sig         = 32'h0;
`endif

endmodule

// File: tb/tb_lcg_stream_checker.sv
// tb/tb_lcg_stream_checker.sv - self-checking bench for lcg_stream_checker with a software LCG model
module tb_lcg_stream_checker;

    localparam int W   = 257;
    localparam int NWB = (W + 31) / 32;
    localparam int CW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_start;
    logic [31:0]   a_seed;
    logic [CW-1:0] a_num;
    logic          a_busy, a_done, a_pass;
    logic [CW-1:0] a_err, a_first, a_cnt;
    logic [31:0]   a_sig;

    logic          b_start;
    logic [31:0]   b_seed;
    logic [CW-1:0] b_num;
    logic          b_busy, b_done, b_pass;
    logic [CW-1:0] b_err, b_first, b_cnt;
    logic [31:0]   b_sig;

    lcg_stream_checker_if #(.DATA_W(64)) s64 ();
    lcg_stream_checker_if #(.DATA_W(W))  sb ();

    lcg_stream_checker #(.DATA_W(64), .CNT_W(CW)) u_a (
        .clk            (clk),
        .rst            (rst),
        .start          (a_start),
        .seed           (a_seed),
        .num_beats      (a_num),
        .s_in           (s64),
        .busy           (a_busy),
        .done           (a_done),
        .pass           (a_pass),
        .err_count      (a_err),
        .first_err_beat (a_first),
        .beat_cnt       (a_cnt),
        .sig            (a_sig)
    );

    lcg_stream_checker #(.DATA_W(W), .CNT_W(CW)) u_b (
        .clk            (clk),
        .rst            (rst),
        .start          (b_start),
        .seed           (b_seed),
        .num_beats      (b_num),
        .s_in           (sb),
        .busy           (b_busy),
        .done           (b_done),
        .pass           (b_pass),
        .err_count      (b_err),
        .first_err_beat (b_first),
        .beat_cnt       (b_cnt),
        .sig            (b_sig)
    );

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] m_lcg(input logic [31:0] s);
        return s * 32'd1103515245 + 32'd12345;
    endfunction

    task automatic m_next_beat(inout logic [31:0] s, output logic [W-1:0] beat);
        logic [NWB*32-1:0] t;
        for (int k = 0; k < NWB; k++) begin
            s = m_lcg(s);
            t[k*32 +: 32] = s;
        end
        beat = t[W-1:0];
    endtask

    function automatic logic [31:0] m_fold(input logic [W-1:0] d);
        logic [NWB*32-1:0] p;
        logic [31:0]       r;
        p        = '0;
        p[W-1:0] = d;
        r        = 32'h0;
        for (int k = 0; k < NWB; k++) r = r ^ p[k*32 +: 32];
        return r;
    endfunction

    function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [W-1:0] d);
`ifdef LCG_CHECK_MISR_EN
        logic [31:0] nx;
        nx = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0);
        return nx ^ m_fold(d);
`else
        return 32'h0 & s & m_fold(d);
`endif
    endfunction

    task automatic chk_b_zero(input string tag);
        chk({tag, "_busy"},  b_busy, 0);
        chk({tag, "_done"},  b_done, 0);
        chk({tag, "_pass"},  b_pass, 0);
        chk({tag, "_ready"}, sb.in_ready, 0);
        chk({tag, "_err"},   b_err, 0);
        chk({tag, "_first"}, b_first, 0);
        chk({tag, "_cnt"},   b_cnt, 0);
        chk({tag, "_sig"},   b_sig, 0);
    endtask

    // One run on the 257-bit checker; beats e1/e2 get bits b1/b2 flipped; abort_at resets before that beat.
    task automatic run_b(input logic [31:0] s0, input int nb, input int e1, input int b1,
                         input int e2, input int b2, input bit gaps, input int abort_at,
                         output logic [31:0] sig_o);
        logic [31:0]  s;
        logic [W-1:0] expb, data;
        logic [31:0]  msig;
        int           exp_err, exp_first, t;
        s = s0; msig = 32'h0; exp_err = 0; exp_first = 0; sig_o = 32'h0;
        @(negedge clk);
        b_seed = s0; b_num = CW'(nb); b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("run_busy_after_start", b_busy, 1);
        chk("run_done_after_start", b_done, 0);
        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk_b_zero("abort_rst");
                rst = 1'b0;
                return;
            end
            m_next_beat(s, expb);
            data = expb;
            if (i == e1) data[b1] = ~data[b1];
            if (i == e2) data[b2] = ~data[b2];
            if (data !== expb) begin
                if (exp_err == 0) exp_first = i;
                exp_err++;
            end
            msig = m_misr(msig, data);
            if (gaps) begin
                sb.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (i == 1) begin
                    b_seed = $urandom; b_num = 3; b_start = 1'b1;
                    @(negedge clk);
                    b_start = 1'b0; b_seed = s0;
                end
            end
            sb.in_valid = 1'b1;
            sb.in_data  = data;
            t = 0;
            while (sb.in_ready !== 1'b1 && t < 64) begin
                @(negedge clk);
                t++;
            end
            if (t >= 64) begin
                chk("ready_timeout", 0, 1);
                sb.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            sb.in_valid = 1'b0;
            chk("beat_cnt_step", b_cnt, i + 1);
        end
        chk("run_done",  b_done, 1);
        chk("run_pass",  b_pass, (exp_err == 0));
        chk("run_err",   b_err, exp_err);
        if (exp_err != 0) chk("run_first", b_first, exp_first);
        chk("run_cnt",   b_cnt, nb);
        chk("run_busy",  b_busy, 0);
        chk("run_ready", sb.in_ready, 0);
        chk("run_sig",   b_sig, msig);
        sig_o = b_sig;
    endtask

    initial begin
        logic [31:0] sig_a, sig_b, sig_c, sig_x;
        int          nb, e1, e2;
        rst = 1'b1;
        a_start = 1'b0; a_seed = '0; a_num = '0;
        b_start = 1'b0; b_seed = '0; b_num = '0;
        s64.in_valid = 1'b0; s64.in_data = '0;
        sb.in_valid  = 1'b0; sb.in_data  = '0;
        repeat (3) @(negedge clk);
        chk_b_zero("reset");
        chk("reset_a_ready", s64.in_ready, 0);
        chk("reset_a_sig", a_sig, 0);
        rst = 1'b0;

        // 64-bit checker, seed 0, one beat, valid held from the start.
        @(negedge clk);
        a_seed = 32'h0; a_num = 1; a_start = 1'b1;
        s64.in_valid = 1'b1; s64.in_data = 64'hD3DC167E_00003039;
        @(negedge clk);
        a_start = 1'b0;
        chk("a_ready_c1", s64.in_ready, 0);
        @(negedge clk);
        chk("a_ready_c2", s64.in_ready, 0);
        @(negedge clk);
        chk("a_ready_c3", s64.in_ready, 1);
        @(negedge clk);
        s64.in_valid = 1'b0;
        chk("a_done", a_done, 1);
        chk("a_pass", a_pass, 1);
        chk("a_err",  a_err, 0);
        chk("a_cnt",  a_cnt, 1);

        // 101-beat runs: two clean, one with two flipped bits.
        run_b(32'd676168421, 101, -1, 0, -1, 0, 1'b0, -1, sig_a);
        run_b(32'd676168421, 101, -1, 0, -1, 0, 1'b0, -1, sig_b);
        run_b(32'd676168421, 101, 7, 256, 40, 0, 1'b0, -1, sig_c);
        chk("err_two",   b_err, 2);
        chk("first_7",   b_first, 7);
        chk("pass_zero", b_pass, 0);
        chk("sig_repeat", sig_b, sig_a);
`ifdef LCG_CHECK_MISR_EN
        chk("sig_nonzero", (sig_a != 32'h0), 1);
        chk("sig_differs", (sig_c != sig_a), 1);
`else
        chk("sig_tied_zero", sig_c, 0);
`endif

        // Zero-length run completes immediately and never offers ready.
        @(negedge clk);
        b_seed = $urandom; b_num = 0; b_start = 1'b1;
        sb.in_valid = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("zero_done", b_done, 1);
        chk("zero_pass", b_pass, 1);
        for (int k = 0; k < 4; k++) begin
            chk("zero_no_ready", sb.in_ready, 0);
            @(negedge clk);
        end
        chk("zero_cnt", b_cnt, 0);
        sb.in_valid = 1'b0;

        // Reset during the fill of beat 3, then a clean single-beat restart.
        run_b($urandom, 5, -1, 0, -1, 0, 1'b0, 3, sig_x);
        run_b(32'h0, 1, -1, 0, -1, 0, 1'b0, -1, sig_x);
        chk("restart_pass", b_pass, 1);

        // Randomised runs with source gaps and ignored mid-run starts.
        for (int r = 0; r < 4; r++) begin
            nb = $urandom_range(2, 12);
            e1 = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            e2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            run_b($urandom, nb, e1, $urandom_range(0, W - 1), e2, $urandom_range(0, W - 1),
                  1'b1, -1, sig_x);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/lcg_stream_checker.md
# lcg_stream_checker

Synthesizable response-side partner to the fuzz harness's LCG stimulus generator. Accepts a stream of DATA_W-bit beats and regenerates the expected beats in hardware from the same 32-bit seed. Compares each received beat against the expected value and reports pass/fail, error count and first failing beat. Sits at the consuming end of a generated stream: in-fabric self-check, loopback of `in_flat`, or replay verification.

## Interface
- DATA_W, 257: bits per beat; expected beat built from NW = ceil(DATA_W/32) LCG words, LSB word first; last word truncated to its low bits.
- CNT_W, 16: width of beat and error counters.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- seed  in  32  initial LCG state, sampled with start.
- num_beats  in  CNT_W  beats expected in the run, sampled with start.
- in_valid  in  1  beat present.
- in_data  in  DATA_W  received beat.
- in_ready  out  1  checker accepts a beat this cycle.
- busy  out  1  run in progress (FILL or READY).
- done  out  1  run complete; held until next start or rst.
- pass  out  1  done && err_count==0.
- err_count  out  CNT_W  mismatching beats; saturates at all-ones.
- first_err_beat  out  CNT_W  index of first mismatching beat; valid when err_count!=0.
- beat_cnt  out  CNT_W  beats accepted this run.
- sig  out  32  MISR signature (see Configuration).

## Operation
- LCG step: next = (s * 32'h41C64E6D + 32'h3039) mod 2^32; each generated word is the post-step state.
- States: IDLE, FILL, READY, DONE.
- IDLE/DONE + start: rng<=seed; word_idx<=0; beat_cnt, err_count, first_err_beat, sig cleared; done<=0. num_beats==0 -> DONE (pass=1), otherwise -> FILL.
- FILL: one LCG step per cycle; exp word[word_idx]<=next; word_idx++. After NW steps -> READY.
- READY: in_ready=1. On in_valid, compare in_data with exp over DATA_W bits and increment beat_cnt.
  - On mismatch, err_count increments (saturating). If err_count was 0, first_err_beat<=beat_cnt.
  - If this was beat num_beats-1 -> DONE, else -> FILL with word_idx<=0.
- in_valid outside READY is ignored; the source must hold the beat until in_ready.
- start while busy is ignored.
- rst at any time: IDLE. All outputs 0, including done, pass, in_ready and sig.

## Timing
- start -> in_ready: NW+1 cycles (NW fill cycles, then READY).
- Throughput: one beat per NW+1 cycles when in_valid is held high.
- Compare result is registered. err_count, beat_cnt and first_err_beat update the cycle after acceptance.
- done/pass rise the cycle after the last accepted beat.
- Reset values: every output 0.

## Configuration
- LCG_CHECK_MISR_EN defined: sig is a 32-bit MISR with polynomial 0x04C11DB7, cleared on start. For each accepted beat, sig <= step(sig) XOR fold32(in_data). fold32 is the XOR of all 32-bit chunks, with the last chunk zero-padded.
- LCG_CHECK_MISR_EN undefined: sig tied to 32'h0 and the MISR logic is absent.

## Structure
- Package lcg_check_pkg holds:
  - LCG_MUL = 32'h41C64E6D, LCG_INC = 32'h3039, MISR_POLY.
  - Function lcg_next.
  - State enum {IDLE, FILL, READY, DONE}.
- Sub-module lcg_step: 32-bit state register with load (seed) and advance enable; outputs current and next state. The top holds the FSM, the expected-beat register, the comparator, the counters and the optional MISR.

## Test plan
- seed=0, num_beats=1, DATA_W=64, send 64'hD3DC167E_00003039 -> pass=1, err_count=0, beat_cnt=1, in_ready first at cycle 3 after start.
- seed=676168421, num_beats=101, DATA_W=257, beats from the software LCG model -> pass=1, beat_cnt=101.
- Same run as above, flip bit 256 of beat 7 and bit 0 of beat 40 -> err_count=2, first_err_beat=7, pass=0.
- num_beats=0 -> done and pass one cycle after start, in_ready never asserted.
- Assert rst during FILL of beat 3, then start seed=0, num_beats=1 -> clean restart; outputs 0 during reset; pass=1 after correct beat.
- With LCG_CHECK_MISR_EN: two identical runs -> identical nonzero sig. Inject a one-bit error -> sig differs. Without the macro -> sig==0.
